// File: rtl/calc_pkg.sv
// Shared constants, rx state encoding and bit-timing helpers for the calculator UART path.
package calc_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_hz, input int unsigned bit_rate);
    return calc_cpb(clk_hz, bit_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART character receiver: 2-FF synchroniser, rx FSM, byte_valid / frame_err strobes.
// Build macro RX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_rx
  import calc_pkg::*;
#(
  parameter int unsigned ClkHz       = 100_000_000,
  parameter int unsigned BitRate     = 9_600,
  parameter int unsigned PayloadBits = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rxd_i,
  output logic [PayloadBits-1:0] data_o,
  output logic                   byte_valid_o,
  output logic                   frame_err_o,
  output logic                   busy_o,
  output logic                   rxd_sync_o
);

  localparam int unsigned Cpb  = calc_cpb(ClkHz, BitRate);
  localparam int unsigned Half = calc_half(ClkHz, BitRate);
  localparam int unsigned CntW = (Cpb > 1) ? $clog2(Cpb) : 1;
  localparam int unsigned BitW = $clog2(PayloadBits + 1);

  localparam logic [CntW-1:0] CpbLast  = CntW'(Cpb - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [BitW-1:0] BitsLast = BitW'(PayloadBits - 1);

  logic sync1_q, sync2_q, prev_q;
  rx_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [PayloadBits-1:0] shift_q, shift_d;
  logic stop_sample, stop_ok;

  // State register; synchroniser flops reset high to match an idle line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef RX_PARITY_EN
  logic parity_q, parity_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  // A parity mismatch is reported at the stop sample, exactly like a bad stop bit.
  assign stop_ok = sync2_q && (parity_q == ^shift_q);
`else
  assign stop_ok = sync2_q;
`endif

  assign stop_sample = (state_q == StStop) && (cnt_q == CpbLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef RX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) begin
          state_d = StStart;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = sync2_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CpbLast) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[PayloadBits-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitsLast) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      StParity: begin
        if (cnt_q == CpbLast) begin
          cnt_d    = '0;
          parity_d = sync2_q;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        if (stop_sample) begin
          cnt_d   = '0;
          state_d = stop_ok ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (sync2_q) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    byte_valid_o = stop_sample && stop_ok;
    frame_err_o  = stop_sample && !stop_ok;
    busy_o       = (state_q != StIdle);
    rxd_sync_o   = sync2_q;
    data_o       = shift_q;
  end

endmodule

// File: rtl/receiver_calc.sv
// Calculator UART receive path: packs received bytes into a message, terminated by CR or a
// full buffer. Build macro RX_PARITY_EN enables even parity in the character receiver.
module receiver_calc
  import calc_pkg::*;
#(
  parameter int unsigned DATASIZE     = 128,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BIT_RATE     = 9_600,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rxd_pin,
  output logic [DATASIZE-1:0]           msg_data,
  output logic [$clog2(DATASIZE/8):0]   msg_len,
  output logic                          msg_valid,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [3:0]                    led
);

  localparam int unsigned MaxBytes = DATASIZE / 8;
  localparam int unsigned LenW     = $clog2(MaxBytes) + 1;

  logic [PAYLOAD_BITS-1:0] rx_data;
  logic [7:0] rx_byte;
  logic rx_valid, rx_frame_err, rx_busy, rx_sync;

  uart_rx #(
    .ClkHz      (CLK_HZ),
    .BitRate    (BIT_RATE),
    .PayloadBits(PAYLOAD_BITS)
  ) u_uart_rx (
    .clk_i       (clk),
    .rst_ni      (resetn),
    .rxd_i       (rxd_pin),
    .data_o      (rx_data),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_frame_err),
    .busy_o      (rx_busy),
    .rxd_sync_o  (rx_sync)
  );

  assign rx_byte = 8'(rx_data);

  logic [DATASIZE-1:0] work_q, work_d, msg_data_q, msg_data_d, shifted;
  logic [LenW-1:0] cnt_q, cnt_d, msg_len_q, msg_len_d, cnt_inc;
  logic msg_valid_q, msg_valid_d, overflow_q, overflow_d;
  logic frame_err_q, frame_err_d, sticky_q, sticky_d;
  logic is_cr, full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work_q      <= '0;
      cnt_q       <= '0;
      msg_data_q  <= '0;
      msg_len_q   <= '0;
      msg_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      msg_data_q  <= msg_data_d;
      msg_len_q   <= msg_len_d;
      msg_valid_q <= msg_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      sticky_q    <= sticky_d;
    end
  end

  always_comb begin
    shifted     = {work_q[DATASIZE-9:0], rx_byte};
    cnt_inc     = cnt_q + 1'b1;
    is_cr       = (rx_byte == ASCII_CR);
    full        = (cnt_inc == LenW'(MaxBytes));
    work_d      = work_q;
    cnt_d       = cnt_q;
    msg_data_d  = msg_data_q;
    msg_len_d   = msg_len_q;
    msg_valid_d = 1'b0;
    overflow_d  = 1'b0;
    frame_err_d = rx_frame_err;
    sticky_d    = sticky_q | rx_frame_err;
    if (rx_frame_err) begin
      // Abort the partial message; the last completed message stays visible.
      work_d = '0;
      cnt_d  = '0;
    end else if (rx_valid) begin
      if (is_cr || full) begin
        msg_data_d  = shifted;
        msg_len_d   = cnt_inc;
        msg_valid_d = 1'b1;
        overflow_d  = !is_cr;
        sticky_d    = sticky_q | !is_cr;
        work_d      = '0;
        cnt_d       = '0;
      end else begin
        work_d = shifted;
        cnt_d  = cnt_inc;
      end
    end
  end

  assign msg_data  = msg_data_q;
  assign msg_len   = msg_len_q;
  assign msg_valid = msg_valid_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign led       = {rx_sync, sticky_q, (cnt_q != '0), rx_busy};

endmodule

// File: tb/tb_receiver_calc.sv
// Scoreboard bench for receiver_calc: directed test-plan frames plus random byte streams.
module tb_receiver_calc;

  localparam int unsigned DataSize = 128;
  localparam int unsigned ClkHz    = 1_000_000;
  localparam int unsigned BitRate  = 100_000;
  localparam int unsigned Cpb      = ClkHz / BitRate;
  localparam int unsigned Half     = Cpb / 2;
  localparam int unsigned MaxBytes = DataSize / 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rxd_pin = 1'b1;
  logic [DataSize-1:0] msg_data;
  logic [4:0] msg_len;
  logic msg_valid, frame_err, overflow;
  logic [3:0] led;

  receiver_calc #(
    .DATASIZE    (DataSize),
    .CLK_HZ      (ClkHz),
    .BIT_RATE    (BitRate),
    .PAYLOAD_BITS(8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rxd_pin  (rxd_pin),
    .msg_data (msg_data),
    .msg_len  (msg_len),
    .msg_valid(msg_valid),
    .frame_err(frame_err),
    .overflow (overflow),
    .led      (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DataSize-1:0] data;
    int unsigned         len;
    bit                  ovf;
  } exp_t;

  exp_t exp_q[$];
  byte unsigned cur_q[$];
  int exp_ferr = 0;
  bit sticky_m = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int k;

  task automatic check(input string name, input logic [DataSize-1:0] act,
                       input logic [DataSize-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a message is the byte list since the last terminator or abort.
  task automatic model_byte(input logic [7:0] b, input bit bad);
    exp_t e;
    if (bad) begin
      exp_ferr++;
      sticky_m = 1'b1;
      cur_q.delete();
      return;
    end
    cur_q.push_back(b);
    if (b == 8'h0D || cur_q.size() == MaxBytes) begin
      e.data = '0;
      foreach (cur_q[i]) e.data = (e.data << 8) | DataSize'(cur_q[i]);
      e.len = cur_q.size();
      e.ovf = (b != 8'h0D);
      if (e.ovf) sticky_m = 1'b1;
      exp_q.push_back(e);
      cur_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    model_byte(b, bad_stop || bad_par);
    rxd_pin = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_pin = b[i];
      repeat (Cpb) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    rxd_pin = (^b) ^ bad_par;
    repeat (Cpb) @(negedge clk);
`endif
    rxd_pin = ~bad_stop;
    repeat (Cpb) @(negedge clk);
    rxd_pin = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (3 * Cpb) @(negedge clk);
    check({name, "_msgs_left"}, DataSize'(exp_q.size()), '0);
    check({name, "_ferr_left"}, DataSize'(exp_ferr), '0);
  endtask

  // Monitor: pops one expectation per msg_valid, accounts for every frame_err pulse.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (msg_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_msg: got msg_len %0d data %0h, expected no message",
                   msg_len, msg_data);
        end else begin
          e = exp_q.pop_front();
          check("msg_data", msg_data, e.data);
          check("msg_len", DataSize'(msg_len), DataSize'(e.len));
          check("overflow", DataSize'(overflow), DataSize'(e.ovf));
        end
      end else if (overflow) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_overflow: got 1 expected 0");
      end
      if (frame_err) begin
        n_checks++;
        if (exp_ferr == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          exp_ferr--;
        end
      end
    end
  end

  initial begin
    string s;
    logic [7:0] b;
    bit bad_s, bad_p;

    resetn  = 1'b0;
    rxd_pin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_msg_data", msg_data, '0);
    check("rst_msg_len", DataSize'(msg_len), '0);
    check("rst_msg_valid", DataSize'(msg_valid), '0);
    check("rst_frame_err", DataSize'(frame_err), '0);
    check("rst_overflow", DataSize'(overflow), '0);
    check("rst_led", DataSize'(led), DataSize'(4'b1000));
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    s = "CALCULATOR";
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, 1'b0);
    send_byte(8'h0A, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b0, 1'b0);
    drain("calc");
    check("calc_sticky", DataSize'(led[2]), '0);

    for (int i = 0; i < 16; i++) send_byte(8'h41, 1'b0, 1'b0);
    drain("full");
    check("full_sticky", DataSize'(led[2]), DataSize'(1));

    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b0, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h4F, 1'b0, 1'b0);
    send_byte(8'h4B, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b0, 1'b0);
    drain("abort");

    // Start-bit glitch: too short to survive the mid-bit sample.
    rxd_pin = 1'b0;
    repeat (3) @(negedge clk);
    rxd_pin = 1'b1;
    k = 0;
    @(negedge clk);
    while (led[0] && k < int'(Half) + 3) begin
      @(negedge clk);
      k++;
    end
    check("glitch_idle", DataSize'(led[0]), '0);
    drain("glitch");
    check("glitch_no_byte", DataSize'(led[1]), '0);

    // Reset in the middle of the 4th data bit of 0x55.
    b = 8'h55;
    rxd_pin = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd_pin = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rxd_pin = b[3];
    repeat (Cpb / 2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_msg_data", msg_data, '0);
    check("mid_rst_msg_len", DataSize'(msg_len), '0);
    check("mid_rst_flags", DataSize'({msg_valid, frame_err, overflow}), '0);
    check("mid_rst_led", DataSize'(led), DataSize'(4'b1000));
    rxd_pin = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    sticky_m = 1'b0;
    cur_q.delete();
    repeat (3) @(negedge clk);
    send_byte(8'h41, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b0, 1'b0);
    drain("post_rst");

`ifdef RX_PARITY_EN
    send_byte(8'h41, 1'b0, 1'b1);
    send_byte(8'h41, 1'b0, 1'b0);
    send_byte(8'h0D, 1'b0, 1'b0);
    drain("parity");
`endif

    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) b = 8'h0D;
      bad_s = ($urandom_range(0, 9) == 0);
      bad_p = 1'b0;
`ifdef RX_PARITY_EN
      bad_p = ($urandom_range(0, 9) == 0);
`endif
      send_byte(b, bad_s, bad_p);
    end
    drain("random");
    check("random_sticky", DataSize'(led[2]), DataSize'(sticky_m));
    check("random_in_progress", DataSize'(led[1]), DataSize'(cur_q.size() != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
